// File: rtl/series_sched.sv
// ----------------------------------------------------------------------------
// series_sched
//
// Issue scheduler for an iterative series evaluator built around an external,
// never-stalling pipeline of fixed latency. New operands enter at in_*,
// partially computed items come back on ret_*, and either re-enter the
// pipeline (recirculate) or complete into a small first-word-fall-through
// result FIFO drained through out_*.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   request handshake, in_x is the operand
//   issue_*             values driven into pipeline stage 0
//   ret_*               values leaving the last pipeline stage
//   out_valid/out_ready result handshake, out_sum/out_overflow = FIFO head
//   flush/flush_done    drain request / one-cycle completion pulse
//   busy                controller not idle
// ----------------------------------------------------------------------------
module series_sched #(
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_ITER   = 7
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,

    output logic        issue_valid,
    output logic [31:0] issue_x,
    output logic [31:0] issue_num,
    output logic [31:0] issue_sum,
    output logic [2:0]  issue_i,
    output logic        issue_flag_next,

    input  logic        ret_valid,
    input  logic [31:0] ret_x,
    input  logic [31:0] ret_num,
    input  logic [31:0] ret_sum,
    input  logic        ret_overflow,
    input  logic [2:0]  ret_i,
    input  logic        ret_flag_next,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_overflow,

    input  logic        flush,
    output logic        flush_done,
    output logic        busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] ONE_Q16 = 32'h0001_0000;
    localparam logic [2:0]  MAX_I   = 3'(MAX_ITER);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   fifo_count_q, fifo_count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    // Entry layout: {sum, overflow}
    logic [32:0]     fifo_mem [FIFO_DEPTH];
    logic [32:0]     fifo_head;

    logic            active;
    logic            below_cap;
    logic            ret_recirc;
    logic            ret_done;
    logic            has_room;
    logic            accept;
    logic            push;
    logic            pop;
    logic            drained;

    // The scheduler never counts pipeline cycles itself: admission control
    // bounds the number of items in the system, so the latency is purely a
    // property of the external pipeline and only documents the contract.
    logic            unused_pipe_depth;
    assign unused_pipe_depth = (PIPE_DEPTH == 0);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Returns are only honoured while the controller is active, so stale
    // pipeline contents surfacing after a reset are dropped.
    assign active     = (state_q != ST_IDLE);
    assign below_cap  = (ret_i < MAX_I);
    assign ret_recirc = active && ret_valid && ret_flag_next && below_cap;
    assign ret_done   = active && ret_valid && !(ret_flag_next && below_cap);

    assign has_room = ((CW+1)'(inflight_q) + (CW+1)'(fifo_count_q)) < (CW+1)'(FIFO_DEPTH);

    // A flush request closes the input in the same cycle it is raised.
    assign in_ready = (state_q == ST_RUN) && !flush && !ret_recirc && has_room;
    assign accept   = in_valid && in_ready;

    assign out_valid = (fifo_count_q != '0);
    assign push      = ret_done;
    assign pop       = out_valid && out_ready;
    assign drained   = (inflight_q == '0) && (fifo_count_q == '0);

    // Issue mux: a recirculating item always wins the pipeline slot.
    always_comb begin
        issue_valid     = ret_recirc || accept;
        issue_flag_next = 1'b1;
        if (ret_recirc) begin
            issue_x   = ret_x;
            issue_num = ret_num;
            issue_sum = ret_sum;
            issue_i   = ret_i;
        end else begin
            issue_x   = in_x;
            issue_num = ONE_Q16;
            issue_sum = ONE_Q16;
            issue_i   = 3'd0;
        end
    end

    // Controller next state and pulse outputs
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        busy       = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush)                     state_d = ST_DRAIN;
                else if (drained && !in_valid) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d    = ST_IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Occupancy counters and FIFO pointers
    always_comb begin
        inflight_d   = inflight_q;
        fifo_count_d = fifo_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (accept && !ret_done)      inflight_d = inflight_q + CW'(1);
        else if (!accept && ret_done) inflight_d = inflight_q - CW'(1);

        if (push && !pop)      fifo_count_d = fifo_count_q + CW'(1);
        else if (!push && pop) fifo_count_d = fifo_count_q - CW'(1);

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Result storage needs no reset: entries are only visible while counted.
    // A done item that still requested another iteration was cut off by the
    // iteration cap, so it is flagged as overflowed.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {ret_sum, ret_overflow | ret_flag_next};
    end

    assign fifo_head    = fifo_mem[rd_ptr_q];
    assign out_sum      = out_valid ? fifo_head[32:1] : 32'h0;
    assign out_overflow = out_valid && fifo_head[0];

endmodule

// File: tb/tb_series_sched.sv
// ----------------------------------------------------------------------------
// tb_series_sched
//
// Directed bench for series_sched. The bench plays the role of the external
// pipeline by driving ret_* by hand at the cycle each issued item is due back
// (four cycles after its issue cycle). Inputs change 2 time units after a
// rising edge; outputs are sampled 1 unit later, well away from the edge.
// ----------------------------------------------------------------------------
module tb_series_sched;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        issue_valid;
    logic [31:0] issue_x;
    logic [31:0] issue_num;
    logic [31:0] issue_sum;
    logic [2:0]  issue_i;
    logic        issue_flag_next;
    logic        ret_valid;
    logic [31:0] ret_x;
    logic [31:0] ret_num;
    logic [31:0] ret_sum;
    logic        ret_overflow;
    logic [2:0]  ret_i;
    logic        ret_flag_next;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_overflow;
    logic        flush;
    logic        flush_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    series_sched #(
        .PIPE_DEPTH(4),
        .FIFO_DEPTH(4),
        .MAX_ITER  (7)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_x           (in_x),
        .issue_valid    (issue_valid),
        .issue_x        (issue_x),
        .issue_num      (issue_num),
        .issue_sum      (issue_sum),
        .issue_i        (issue_i),
        .issue_flag_next(issue_flag_next),
        .ret_valid      (ret_valid),
        .ret_x          (ret_x),
        .ret_num        (ret_num),
        .ret_sum        (ret_sum),
        .ret_overflow   (ret_overflow),
        .ret_i          (ret_i),
        .ret_flag_next  (ret_flag_next),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sum        (out_sum),
        .out_overflow   (out_overflow),
        .flush          (flush),
        .flush_done     (flush_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ret_set(input logic flag, input logic [2:0] i, input logic [31:0] x,
                           input logic [31:0] num, input logic [31:0] sum, input logic ovf);
        ret_valid     = 1'b1;
        ret_flag_next = flag;
        ret_i         = i;
        ret_x         = x;
        ret_num       = num;
        ret_sum       = sum;
        ret_overflow  = ovf;
    endtask

    task automatic ret_clr();
        ret_valid     = 1'b0;
        ret_flag_next = 1'b0;
        ret_i         = 3'd0;
        ret_x         = 32'h0;
        ret_num       = 32'h0;
        ret_sum       = 32'h0;
        ret_overflow  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = 32'h0;
        out_ready = 1'b0;
        flush     = 1'b0;
        ret_clr();
        #1;

        // ---------------- reset state ----------------
        chk("rst_in_ready",     32'(in_ready),     32'd0);
        chk("rst_issue_valid",  32'(issue_valid),  32'd0);
        chk("rst_out_valid",    32'(out_valid),    32'd0);
        chk("rst_out_sum",      out_sum,           32'h0);
        chk("rst_out_overflow", 32'(out_overflow), 32'd0);
        chk("rst_flush_done",   32'(flush_done),   32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        tick();
        tick();
        rst = 1'b0;
        $display("step reset released");

        // ---------------- single item, latency ----------------
        in_valid = 1'b1;
        in_x     = 32'h0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        tick();                                   // C1: RUN, accept
        #1;
        chk("new_in_ready",   32'(in_ready),        32'd1);
        chk("new_issue_vld",  32'(issue_valid),     32'd1);
        chk("new_issue_x",    issue_x,              32'h0);
        chk("new_issue_num",  issue_num,            32'h0001_0000);
        chk("new_issue_sum",  issue_sum,            32'h0001_0000);
        chk("new_issue_i",    32'(issue_i),         32'd0);
        chk("new_issue_flag", 32'(issue_flag_next), 32'd1);
        tick();                                   // C2
        in_valid = 1'b0;
        tick();                                   // C3
        tick();                                   // C4
        tick();                                   // C5: item due back
        ret_set(1'b0, 3'd0, 32'h0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        #1;
        chk("single_out_early", 32'(out_valid), 32'd0);
        tick();                                   // C6 = accept + PIPE_DEPTH + 1
        ret_clr();
        #1;
        chk("single_out_valid", 32'(out_valid),    32'd1);
        chk("single_out_sum",   out_sum,           32'h0001_0000);
        chk("single_out_ovf",   32'(out_overflow), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("single_popped", 32'(out_valid), 32'd0);
        tick();
        #1;
        chk("single_idle_busy", 32'(busy), 32'd0);
        $display("step single item done");

        // ---------------- recirculation priority ----------------
        in_valid = 1'b1;
        in_x     = 32'd5;
        tick();                                   // C1: accept A
        tick();                                   // C2
        in_valid = 1'b0;
        tick();                                   // C3
        tick();                                   // C4
        tick();                                   // C5: A returns, wants more
        ret_set(1'b1, 3'd1, 32'd5, 32'h0002_0000, 32'h0001_8000, 1'b0);
        in_valid = 1'b1;
        in_x     = 32'd9;
        #1;
        chk("recirc_issue_vld", 32'(issue_valid), 32'd1);
        chk("recirc_issue_i",   32'(issue_i),     32'd1);
        chk("recirc_issue_x",   issue_x,          32'd5);
        chk("recirc_issue_num", issue_num,        32'h0002_0000);
        chk("recirc_issue_sum", issue_sum,        32'h0001_8000);
        chk("recirc_in_ready",  32'(in_ready),    32'd0);
        tick();                                   // C6: B accepted now
        ret_clr();
        #1;
        chk("recirc_next_ready", 32'(in_ready),    32'd1);
        chk("recirc_next_issue", 32'(issue_valid), 32'd1);
        chk("recirc_next_x",     issue_x,          32'd9);
        chk("recirc_next_i",     32'(issue_i),     32'd0);
        tick();                                   // C7
        in_valid = 1'b0;
        tick();                                   // C8
        tick();                                   // C9: A done
        ret_set(1'b0, 3'd2, 32'd5, 32'h0, 32'h0000_0111, 1'b0);
        tick();                                   // C10: B done
        ret_set(1'b0, 3'd1, 32'd9, 32'h0, 32'h0000_0222, 1'b1);
        #1;
        chk("order_first_vld", 32'(out_valid), 32'd1);
        chk("order_first_sum", out_sum,        32'h0000_0111);
        tick();                                   // C11
        ret_clr();
        out_ready = 1'b1;
        #1;
        chk("order_head_sum", out_sum,           32'h0000_0111);
        chk("order_head_ovf", 32'(out_overflow), 32'd0);
        tick();                                   // C12
        #1;
        chk("order_second_sum", out_sum,           32'h0000_0222);
        chk("order_second_ovf", 32'(out_overflow), 32'd1);
        tick();                                   // C13
        out_ready = 1'b0;
        #1;
        chk("order_empty", 32'(out_valid), 32'd0);
        tick();
        #1;
        chk("order_idle_busy", 32'(busy), 32'd0);
        $display("step recirculation done");

        // ---------------- iteration cap ----------------
        in_valid = 1'b1;
        in_x     = 32'd3;
        tick();                                   // C1: accept
        tick();                                   // C2
        in_valid = 1'b0;
        tick();                                   // C3
        tick();                                   // C4
        tick();                                   // C5: i=6 still recirculates
        ret_set(1'b1, 3'd6, 32'd3, 32'h1, 32'h0003_0000, 1'b0);
        #1;
        chk("cap_i6_issue", 32'(issue_valid), 32'd1);
        chk("cap_i6_i",     32'(issue_i),     32'd6);
        tick();                                   // C6
        ret_clr();
        tick();                                   // C7
        tick();                                   // C8
        tick();                                   // C9: i=7 forced complete
        ret_set(1'b1, 3'd7, 32'd3, 32'h1, 32'h0000_ABCD, 1'b0);
        #1;
        chk("cap_i7_no_issue", 32'(issue_valid), 32'd0);
        chk("cap_i7_in_ready", 32'(in_ready),    32'd1);
        tick();                                   // C10
        ret_clr();
        #1;
        chk("cap_out_valid", 32'(out_valid),    32'd1);
        chk("cap_out_sum",   out_sum,           32'h0000_ABCD);
        chk("cap_out_ovf",   32'(out_overflow), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("cap_popped", 32'(out_valid), 32'd0);
        tick();
        $display("step iteration cap done");

        // ---------------- capacity ----------------
        in_valid = 1'b1;
        in_x     = 32'h100;
        tick();                                   // C1: RUN
        for (int k = 0; k < 4; k++) begin         // C1..C4 accept
            #1;
            chk("cap4_accept_ready", 32'(in_ready), 32'd1);
            tick();
            in_x = in_x + 32'd1;
        end
        ret_set(1'b0, 3'd0, 32'h100, 32'h0, 32'h0000_0011, 1'b0);   // C5
        #1;
        chk("cap4_full_ready", 32'(in_ready),    32'd0);
        chk("cap4_full_issue", 32'(issue_valid), 32'd0);
        tick();                                   // C6
        ret_set(1'b0, 3'd0, 32'h101, 32'h0, 32'h0000_0022, 1'b0);
        #1;
        chk("cap4_c6_ready", 32'(in_ready), 32'd0);
        tick();                                   // C7
        ret_set(1'b0, 3'd0, 32'h102, 32'h0, 32'h0000_0033, 1'b0);
        tick();                                   // C8
        ret_set(1'b0, 3'd0, 32'h103, 32'h0, 32'h0000_0044, 1'b0);
        tick();                                   // C9: FIFO full
        ret_clr();
        #1;
        chk("cap4_fifo_full_ready", 32'(in_ready), 32'd0);
        chk("cap4_head_sum",        out_sum,       32'h0000_0011);
        out_ready = 1'b1;
        tick();                                   // C10: one popped
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("cap4_after_pop_ready", 32'(in_ready), 32'd1);
        chk("cap4_next_head",       out_sum,       32'h0000_0022);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        chk("cap4_drained", 32'(out_valid), 32'd0);
        tick();
        $display("step capacity done");

        // ---------------- flush ----------------
        in_valid = 1'b1;
        in_x     = 32'h7;
        tick();                                   // C1: accept X
        tick();                                   // C2: accept Y
        tick();                                   // C3: flush raised
        flush = 1'b1;
        #1;
        chk("flush_in_ready_now", 32'(in_ready),    32'd0);
        chk("flush_no_issue",     32'(issue_valid), 32'd0);
        chk("flush_busy",         32'(busy),        32'd1);
        tick();                                   // C4: DRAIN, repeat flush ignored
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        tick();                                   // C5: X done
        flush    = 1'b0;
        in_valid = 1'b0;
        ret_set(1'b0, 3'd1, 32'h7, 32'h0, 32'h0000_0055, 1'b0);
        #1;
        chk("drain_no_done_c5", 32'(flush_done), 32'd0);
        tick();                                   // C6: Y recirculates in DRAIN
        ret_set(1'b1, 3'd3, 32'h7, 32'h0, 32'h0000_0060, 1'b0);
        #1;
        chk("drain_recirc_issue", 32'(issue_valid), 32'd1);
        chk("drain_head_sum",     out_sum,          32'h0000_0055);
        out_ready = 1'b1;
        tick();                                   // C7
        ret_clr();
        #1;
        chk("drain_popped_x", 32'(out_valid), 32'd0);
        tick();                                   // C8
        tick();                                   // C9
        tick();                                   // C10: Y done
        ret_set(1'b0, 3'd4, 32'h7, 32'h0, 32'h0000_0066, 1'b0);
        #1;
        chk("drain_no_done_c10", 32'(flush_done), 32'd0);
        tick();                                   // C11
        ret_clr();
        #1;
        chk("drain_head_y",      out_sum,         32'h0000_0066);
        chk("drain_no_done_c11", 32'(flush_done), 32'd0);
        tick();                                   // C12: drained
        #1;
        chk("flush_done_pulse", 32'(flush_done), 32'd1);
        tick();                                   // C13
        out_ready = 1'b0;
        #1;
        chk("flush_done_clear", 32'(flush_done), 32'd0);
        chk("flush_after_busy", 32'(busy),       32'd0);
        $display("step flush done");

        // ---------------- asynchronous reset ----------------
        in_valid = 1'b1;
        in_x     = 32'h20;
        tick();                                   // C1
        tick();                                   // C2
        tick();                                   // C3
        tick();                                   // C4: three items in flight
        #1;
        chk("pre_rst_issue", 32'(issue_valid), 32'd1);
        #1;
        rst = 1'b1;                               // between edges
        #1;
        chk("arst_in_ready",   32'(in_ready),    32'd0);
        chk("arst_issue",      32'(issue_valid), 32'd0);
        chk("arst_busy",       32'(busy),        32'd0);
        chk("arst_out_valid",  32'(out_valid),   32'd0);
        chk("arst_flush_done", 32'(flush_done),  32'd0);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        ret_set(1'b1, 3'd1, 32'h20, 32'h0, 32'h0, 1'b0);   // stale recirculate
        #1;
        chk("stale_no_issue", 32'(issue_valid), 32'd0);
        tick();
        ret_set(1'b0, 3'd1, 32'h20, 32'h0, 32'h0000_0099, 1'b0); // stale done
        tick();
        ret_clr();
        #1;
        chk("stale_no_push", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        tick();                                   // RUN
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stale_cap_ready", 32'(in_ready), 32'd1);
            tick();
        end
        #1;
        chk("stale_cap_full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        $display("step async reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
